// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - decode patterns and state encoding shared by the mem_stage slice
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LDWB = 2'd2
  } state_e;

  localparam logic [31:0] DECODE_LDRSTR_MASK = 32'h0C00_0000;
  localparam logic [31:0] DECODE_LDRSTR_VAL  = 32'h0400_0000;
  localparam logic [31:0] DECODE_UNDEF_MASK  = 32'h0E00_0010;
  localparam logic [31:0] DECODE_UNDEF_VAL   = 32'h0600_0010;

  function automatic logic is_mem_insn(input logic [31:0] insn);
    return ((insn & DECODE_LDRSTR_MASK) == DECODE_LDRSTR_VAL) &&
           ((insn & DECODE_UNDEF_MASK) != DECODE_UNDEF_VAL);
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte lane rotate/select for loads, byte replicate and enables for stores
module mem_align (
  input  logic [1:0]  addr_lo,
  input  logic        byte_op,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata_in,
  output logic [31:0] ld_data,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  logic [31:0] rot;

  // Rotating right by the byte offset puts the addressed byte in lane 0,
  // so the byte load is just the low byte of the rotated word.
  always_comb begin
    case (addr_lo)
      2'd1:    rot = {rdata[7:0],  rdata[31:8]};
      2'd2:    rot = {rdata[15:0], rdata[31:16]};
      2'd3:    rot = {rdata[23:0], rdata[31:24]};
      default: rot = rdata;
    endcase
  end

  assign ld_data = byte_op ? {24'd0, rot[7:0]} : rot;
  assign be      = byte_op ? (4'b0001 << addr_lo) : 4'hF;
  assign wdata   = byte_op ? {4{wdata_in[7:0]}} : wdata_in;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - LDR/STR/LDRB/STRB memory stage with base writeback and r15 load redirect
// Optional MEM_STAGE_ALIGN_ABORT_EN: unaligned word access raises abort instead of a bus cycle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              Nrst,
  input  logic              stall,
  input  logic              flush,
  input  logic              inbubble,
  input  logic [31:0]       pc,
  input  logic [31:0]       insn,
  input  logic [31:0]       op0,
  input  logic [31:0]       op1,
  input  logic [31:0]       op2,
  input  logic              write_reg,
  input  logic [3:0]        write_num,
  input  logic [31:0]       write_data,
  output logic              outstall,
  output logic              outbubble,
  output logic              out_write_reg,
  output logic [3:0]        out_write_num,
  output logic [31:0]       out_write_data,
  output logic              jmp,
  output logic [31:0]       jmppc,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
`ifdef MEM_STAGE_ALIGN_ABORT_EN
  output logic              abort,
`endif
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata
);

  state_e      state_q, state_d;
  logic [31:0] ea_q, ea_d, off_q, off_d, sdata_q, sdata_d, ld_q, ld_d;
  logic        l_q, l_d, b_q, b_d, wb_q, wb_d, rdy_pend_q, rdy_pend_d;
  logic [3:0]  rn_q, rn_d, rd_q, rd_d;
  logic        outbubble_q, outbubble_d, owr_q, owr_d, jmp_q, jmp_d;
  logic [3:0]  onum_q, onum_d;
  logic [31:0] odata_q, odata_d, jmppc_q, jmppc_d;

  logic [31:0] off, ea, ld_new, ld_now, al_wdata;
  logic [3:0]  al_be;
  logic        mem_hit, in_req, rdy, do_abort;
  logic        unused_in;

  assign unused_in = ^{pc, insn[31:28], insn[11:0]};

  assign mem_hit = is_mem_insn(insn) && !inbubble && !flush;
  assign off     = insn[23] ? op0 + op1 : op0 - op1;
  assign ea      = insn[24] ? off : op0;
  assign in_req  = (state_q == ST_REQ);
  assign rdy     = bus_ready || rdy_pend_q;
  assign ld_now  = rdy_pend_q ? ld_q : ld_new;

`ifdef MEM_STAGE_ALIGN_ABORT_EN
  logic abort_q, abort_d;
  assign do_abort = mem_hit && !insn[22] && (ea[1:0] != 2'b00);
  assign abort_d  = stall ? abort_q : do_abort;
  assign abort    = abort_q;
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) abort_q <= 1'b0;
    else       abort_q <= abort_d;
  end
`else
  assign do_abort = 1'b0;
`endif

  mem_align u_align (
    .addr_lo  (ea_q[1:0]),
    .byte_op  (b_q),
    .rdata    (bus_rdata),
    .wdata_in (sdata_q),
    .ld_data  (ld_new),
    .be       (al_be),
    .wdata    (al_wdata)
  );

  always_comb begin
    state_d = state_q;   ea_d = ea_q;     off_d = off_q;   sdata_d = sdata_q;
    ld_d = ld_q;         l_d = l_q;       b_d = b_q;       wb_d = wb_q;
    rn_d = rn_q;         rd_d = rd_q;     rdy_pend_d = rdy_pend_q;
    outbubble_d = outbubble_q; owr_d = owr_q; onum_d = onum_q; odata_d = odata_q;
    jmp_d = jmp_q;       jmppc_d = jmppc_q;
    outstall = 1'b1;
    // First bus_ready of a transfer is captured even under stall; later beats are ignored.
    if (in_req && bus_ready && !rdy_pend_q) ld_d = ld_new;
    if (stall) begin
      if (in_req && bus_ready) rdy_pend_d = 1'b1;
    end else begin
      outbubble_d = 1'b1;
      owr_d       = 1'b0;
      jmp_d       = 1'b0;
      case (state_q)
        ST_IDLE: begin
          outstall = 1'b0;
          if (do_abort) begin
            outbubble_d = 1'b0;
          end else if (mem_hit) begin
            ea_d = ea;  off_d = off;  sdata_d = op2;
            l_d = insn[20];  b_d = insn[22];  wb_d = !insn[24] || insn[21];
            rn_d = insn[19:16];  rd_d = insn[15:12];
            state_d = ST_REQ;
            outstall = 1'b1;
          end else begin
            outbubble_d = inbubble || flush;
            owr_d       = write_reg && !(inbubble || flush);
            onum_d      = write_num;
            odata_d     = write_data;
          end
        end
        ST_REQ: begin
          if (rdy) begin
            rdy_pend_d  = 1'b0;
            outbubble_d = 1'b0;
            state_d     = ST_IDLE;
            outstall    = 1'b0;
            if (wb_q) begin
              owr_d = 1'b1;  onum_d = rn_q;  odata_d = off_q;
              if (l_q) begin
                state_d  = ST_LDWB;
                outstall = 1'b1;
              end
            end else if (l_q) begin
              owr_d = 1'b1;  onum_d = rd_q;  odata_d = ld_now;
              jmp_d = (rd_q == 4'd15);  jmppc_d = ld_now;
            end
          end
        end
        ST_LDWB: begin
          outbubble_d = 1'b0;
          owr_d = 1'b1;  onum_d = rd_q;  odata_d = ld_q;
          jmp_d = (rd_q == 4'd15);  jmppc_d = ld_q;
          state_d  = ST_IDLE;
          outstall = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      state_q <= ST_IDLE;  ea_q <= '0;  off_q <= '0;  sdata_q <= '0;  ld_q <= '0;
      l_q <= 1'b0;  b_q <= 1'b0;  wb_q <= 1'b0;  rdy_pend_q <= 1'b0;
      rn_q <= '0;  rd_q <= '0;
      outbubble_q <= 1'b1;  owr_q <= 1'b0;  onum_q <= '0;  odata_q <= '0;
      jmp_q <= 1'b0;  jmppc_q <= '0;
    end else begin
      state_q <= state_d;  ea_q <= ea_d;  off_q <= off_d;  sdata_q <= sdata_d;  ld_q <= ld_d;
      l_q <= l_d;  b_q <= b_d;  wb_q <= wb_d;  rdy_pend_q <= rdy_pend_d;
      rn_q <= rn_d;  rd_q <= rd_d;
      outbubble_q <= outbubble_d;  owr_q <= owr_d;  onum_q <= onum_d;  odata_q <= odata_d;
      jmp_q <= jmp_d;  jmppc_q <= jmppc_d;
    end
  end

  assign outbubble      = outbubble_q;
  assign out_write_reg  = owr_q;
  assign out_write_num  = onum_q;
  assign out_write_data = odata_q;
  assign jmp            = jmp_q;
  assign jmppc          = jmppc_q;
  assign bus_req        = in_req;
  assign bus_wr         = in_req && !l_q;
  assign bus_addr       = in_req ? {ea_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be         = in_req ? al_be : 4'h0;
  assign bus_wdata      = (in_req && !l_q) ? al_wdata : 32'd0;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with randomized traffic and a bus responder
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        Nrst, stall, flush, inbubble;
  logic [31:0] pc, insn, op0, op1, op2;
  logic        write_reg;
  logic [3:0]  write_num;
  logic [31:0] write_data;
  logic        outstall, outbubble, out_write_reg, jmp;
  logic [3:0]  out_write_num;
  logic [31:0] out_write_data, jmppc;
  logic        bus_req, bus_wr, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
`ifdef MEM_STAGE_ALIGN_ABORT_EN
  logic        abort;
`endif

  typedef struct {
    logic        wr;
    logic [3:0]  num;
    logic [31:0] data;
    logic        jmp;
    logic [31:0] jpc;
    logic        abt;
  } emit_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } bus_t;

  emit_t exp_q[$];
  bus_t  bus_q[$];
  int    total = 0;
  int    bad = 0;
  int    resp_delay = -1;
  logic  adv = 1'b0;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .Nrst(Nrst), .stall(stall), .flush(flush), .inbubble(inbubble),
    .pc(pc), .insn(insn), .op0(op0), .op1(op1), .op2(op2),
    .write_reg(write_reg), .write_num(write_num), .write_data(write_data),
    .outstall(outstall), .outbubble(outbubble), .out_write_reg(out_write_reg),
    .out_write_num(out_write_num), .out_write_data(out_write_data),
    .jmp(jmp), .jmppc(jmppc), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
`ifdef MEM_STAGE_ALIGN_ABORT_EN
    .abort(abort),
`endif
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic emit_t mk(input logic wr, input logic [3:0] num, input logic [31:0] data,
                               input logic j, input logic [31:0] jpc, input logic abt);
    emit_t e;
    e.wr = wr; e.num = num; e.data = data; e.jmp = j; e.jpc = jpc; e.abt = abt;
    return e;
  endfunction

  // Little-endian view: result byte k comes from memory byte (k+offset) mod 4.
  function automatic logic [31:0] ld_ref(input logic [31:0] rd, input int lo, input bit b);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = rd[8*((k + lo) % 4) +: 8];
    if (b) r = {24'd0, rd[8*lo +: 8]};
    return r;
  endfunction

  task automatic issue(input logic [31:0] i_insn, input logic [31:0] i_op0, input logic [31:0] i_op1,
                       input logic [31:0] i_op2, input logic i_wr, input logic [3:0] i_num,
                       input logic [31:0] i_data, input logic i_bub, input logic i_fl,
                       input logic [31:0] rdata, input int stall_pct, output int n_high);
    bit          is_mem, b, l, wb, abt, acc;
    logic [31:0] off, ea, ld;
    logic [3:0]  rn, rd;
    int          lo, n;
    bus_t        bt;
    is_mem = (i_insn[27:26] == 2'b01) && !(i_insn[25] && i_insn[4]);
    if (!i_bub && !i_fl) begin
      if (!is_mem) exp_q.push_back(mk(i_wr, i_num, i_data, 1'b0, 32'd0, 1'b0));
      else begin
        off = i_insn[23] ? i_op0 + i_op1 : i_op0 - i_op1;
        ea  = i_insn[24] ? off : i_op0;
        lo  = int'(ea[1:0]);
        b = i_insn[22]; l = i_insn[20]; wb = !i_insn[24] || i_insn[21];
        rn = i_insn[19:16]; rd = i_insn[15:12];
        ld = ld_ref(rdata, lo, b);
        abt = 1'b0;
`ifdef MEM_STAGE_ALIGN_ABORT_EN
        abt = !b && (lo != 0);
`endif
        if (abt) exp_q.push_back(mk(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b1));
        else begin
          bt.wr = !l; bt.addr = ea & ~32'h3; bt.be = b ? (4'b0001 << lo) : 4'hF;
          bt.wdata = b ? {4{i_op2[7:0]}} : i_op2; bt.rdata = rdata;
          bus_q.push_back(bt);
          if (wb) exp_q.push_back(mk(1'b1, rn, off, 1'b0, 32'd0, 1'b0));
          if (l) exp_q.push_back(mk(1'b1, rd, ld, rd == 4'd15, ld, 1'b0));
          else if (!wb) exp_q.push_back(mk(1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0));
        end
      end
    end
    pc = $urandom; insn = i_insn; op0 = i_op0; op1 = i_op1; op2 = i_op2;
    write_reg = i_wr; write_num = i_num; write_data = i_data; inbubble = i_bub; flush = i_fl;
    n_high = 0; n = 0;
    forever begin
      stall = ($urandom_range(99) < stall_pct);
      @(negedge clk);
      acc = !outstall;
      if (outstall) n_high++;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 300) begin
        total++; bad++;
        $display("FAIL accept_timeout: got outstall=1 want 0 within 300 cycles");
        break;
      end
    end
    stall = 1'b0;
  endtask

  always @(posedge clk) adv <= Nrst && !stall;

  initial begin : monitor
    emit_t e;
    forever begin
      @(negedge clk);
      if (adv) begin
`ifdef MEM_STAGE_ALIGN_ABORT_EN
        if (!outbubble || abort) begin
`else
        if (!outbubble) begin
`endif
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_emit: got num=%h data=%h want none", out_write_num, out_write_data);
          end else begin
            e = exp_q.pop_front();
            chk("wr_en", {31'd0, out_write_reg}, {31'd0, e.wr});
            if (e.wr) begin
              chk("wr_num", {28'd0, out_write_num}, {28'd0, e.num});
              chk("wr_data", out_write_data, e.data);
            end
            chk("jmp", {31'd0, jmp}, {31'd0, e.jmp});
            if (e.jmp) chk("jmppc", jmppc, e.jpc);
`ifdef MEM_STAGE_ALIGN_ABORT_EN
            chk("abort", {31'd0, abort}, {31'd0, e.abt});
`endif
          end
        end else begin
          chk("bubble_wr", {31'd0, out_write_reg}, 32'd0);
          chk("bubble_jmp", {31'd0, jmp}, 32'd0);
        end
      end
    end
  end

  initial begin : responder
    bus_t b;
    int   d, n;
    bit   gone;
    bus_ready = 1'b0; bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (bus_req && Nrst) begin
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_bus_req: got addr=%h want no request", bus_addr);
          b.addr = bus_addr; b.rdata = 32'd0;
        end else begin
          b = bus_q.pop_front();
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_be", {28'd0, bus_be}, {28'd0, b.be});
          chk("bus_wr", {31'd0, bus_wr}, {31'd0, b.wr});
          if (b.wr) chk("bus_wdata", bus_wdata, b.wdata);
        end
        d = (resp_delay >= 0) ? resp_delay : $urandom_range(3);
        gone = 1'b0;
        repeat (d) begin
          @(negedge clk);
          if (!bus_req) gone = 1'b1;
          else chk("bus_addr_hold", bus_addr, b.addr);
        end
        if (!gone) begin
          @(posedge clk); #1;
          bus_ready = 1'b1; bus_rdata = b.rdata;
          @(posedge clk); #1;
          bus_ready = 1'b0; bus_rdata = $urandom;
        end
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (bus_req && n < 400);
        if (bus_req) begin
          total++; bad++;
          $display("FAIL bus_req_stuck: got 1 want 0");
        end
      end
    end
  end

  initial begin : driver
    int          nh;
    logic [31:0] ins, o1;
    bus_t        bt;
    Nrst = 1'b0; stall = 1'b0; flush = 1'b0; inbubble = 1'b1; pc = '0; insn = '0;
    op0 = '0; op1 = '0; op2 = '0; write_reg = 1'b0; write_num = '0; write_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outbubble", {31'd0, outbubble}, 32'd1);
    chk("rst_wr_en", {31'd0, out_write_reg}, 32'd0);
    chk("rst_wr_num", {28'd0, out_write_num}, 32'd0);
    chk("rst_wr_data", out_write_data, 32'd0);
    chk("rst_jmp", {31'd0, jmp}, 32'd0);
    chk("rst_jmppc", jmppc, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_wr", {31'd0, bus_wr}, 32'd0);
    chk("rst_bus_be", {28'd0, bus_be}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    Nrst = 1'b1;
    @(posedge clk); #1;

    resp_delay = 1;
    issue(32'hE592_1004, 32'h1000, 32'd4, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 0, nh);
    chk("ldr_outstall_cycles", nh, 3);
    issue(32'hE4D4_3001, 32'h2003, 32'd1, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 32'h1122_3344, 0, nh);
    issue(32'hE546_5002, 32'h3006, 32'd2, 32'hAB, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 32'd0, 0, nh);
    issue(32'hE590_F000, 32'h400, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 32'h8000, 0, nh);

    issue(32'hE082_1003, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 32'd0, 0, nh);
    insn = 32'hE082_1003; write_reg = 1'b1; write_num = 4'd1; write_data = 32'h55;
    inbubble = 1'b0; flush = 1'b0; stall = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_outstall", {31'd0, outstall}, 32'd1);
      chk("stall_frozen_bubble", {31'd0, outbubble}, 32'd1);
      @(posedge clk); #1;
    end
    issue(32'hE082_1003, 32'd0, 32'd0, 32'd0, 1'b1, 4'd1, 32'h55, 1'b0, 1'b0, 32'd0, 0, nh);

    issue(32'hE592_1004, 32'h1000, 32'd4, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 32'd0, 0, nh);
    @(negedge clk);
    chk("flush_outbubble", {31'd0, outbubble}, 32'd1);
    chk("flush_no_req", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;

    resp_delay = -1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(9) < 6) begin
        ins = $urandom;
        ins[27:26] = 2'b01;
        if (ins[25] && $urandom_range(3) != 0) ins[4] = 1'b0;
      end else begin
        ins = $urandom;
        if (ins[27:26] == 2'b01) ins[27] = 1'b1;
      end
      o1 = ($urandom_range(1) == 1) ? 32'($urandom_range(4095)) : $urandom;
      issue(ins, $urandom, o1, $urandom, 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom,
            $urandom_range(9) == 0, $urandom_range(9) == 0, $urandom, 20, nh);
    end
    inbubble = 1'b1; flush = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    resp_delay = 20;
    insn = 32'hE592_1004; op0 = 32'h1000; op1 = 32'd4; inbubble = 1'b0;
    bt.wr = 1'b0; bt.addr = 32'h1004; bt.be = 4'hF; bt.wdata = 32'd0; bt.rdata = 32'h0;
    bus_q.push_back(bt);
    nh = 0;
    do begin
      @(negedge clk);
      nh++;
    end while (!bus_req && nh < 20);
    chk("rst_test_req_seen", {31'd0, bus_req}, 32'd1);
    #1;
    inbubble = 1'b1; Nrst = 1'b0;
    #1;
    chk("midreq_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("midreq_rst_outbubble", {31'd0, outbubble}, 32'd1);
    chk("midreq_rst_idle", {31'd0, outstall}, 32'd0);
    chk("midreq_rst_bus_be", {28'd0, bus_be}, 32'd0);
    @(posedge clk); #1;
    Nrst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_bus_req", {31'd0, bus_req}, 32'd0);
    repeat (4) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("bus_q_drained", bus_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
